data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data_mem between the riscv data port and a DMA/debug master.
//  CPU has fixed priority; DMA uses CPU-idle cycles (data_ce_o=0).
//  A starvation counter forces one DMA slot, stalling the CPU for that cycle.
//  Sits between riscv data_*_o/data_i and data_mem ce/we/addr/data_i/data_o.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  STARVE_MAX  8   denied DMA cycles before a forced grant; legal range 1..255
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, asynchronous, active-high
//  cpu_ce_i      in   1   CPU data access request
//  cpu_we_i      in   1   CPU write enable
//  cpu_addr_i    in   AW  CPU address
//  cpu_data_i    in   DW  CPU write data
//  cpu_data_o    out  DW  CPU read data
//  cpu_stall_o   out  1   CPU must hold PC and suppress its access this cycle
//  dma_req_i     in   1   DMA transfer request; held until granted
//  dma_we_i      in   1   DMA write enable
//  dma_addr_i    in   AW  DMA address
//  dma_data_i    in   DW  DMA write data
//  dma_gnt_o     out  1   DMA transfer performed this cycle
//  dma_rvalid_o  out  1   DMA read data valid, one cycle after a granted read
//  dma_rdata_o   out  DW  registered DMA read data
//  mem_ce_o/mem_we_o/mem_addr_o/mem_data_o  out 1/1/AW/DW  to data_mem
//  mem_data_i    in   DW  data_mem combinational read data
// BEHAVIOUR
//  Memory contract: write on rising clk when ce&we; read combinational when ce.
//  Registered state: force_q (1b), starve_cnt (8b), dma_rvalid_o, dma_rdata_o.
//  Grant (comb): dma_gnt_o = !rst & dma_req_i & (!cpu_ce_i | force_q).
//  cpu_stall_o (comb) = !rst & force_q & dma_req_i.
//  Mux: dma_gnt_o=1 -> mem_* driven from dma_*; else mem_ce_o=cpu_ce_i & !rst,
//   and mem_we_o/addr/data are driven from cpu_*.
//  cpu_data_o = mem_data_i when CPU owns and cpu_ce_i=1, else 0.
//  starve_cnt: 0 when !dma_req_i or dma_gnt_o; else +1, saturating at STARVE_MAX.
//  force_q: set when dma_req_i & !dma_gnt_o & starve_cnt==STARVE_MAX-1;
//   cleared after any cycle with force_q=1 (one forced slot only).
//   If dma_req_i drops while force_q=1: no grant, no stall, force_q clears.
//  Read return: a granted read (dma_gnt_o & !dma_we_i) -> next cycle dma_rvalid_o=1,
//   dma_rdata_o=mem_data_i captured at the grant edge. dma_rvalid_o is otherwise 0.
//   dma_rdata_o holds its value between reads.
//  Burst: each granted cycle = one transfer; DMA presents its next beat after dma_gnt_o.
//  Latency: uncontended DMA is granted in the cycle of dma_req_i. Worst case is
//   STARVE_MAX+1 cycles.
//  Reset (async): force_q=0, starve_cnt=0, dma_rvalid_o=0, dma_rdata_o=0.
//   While rst=1: mem_ce_o=0, mem_we_o=0, dma_gnt_o=0, cpu_stall_o=0, cpu_data_o=0.
//   Reset mid-burst drops the transfer; DMA must re-request.
// TESTING
//  1 CPU write: cpu_ce=1 we=1 addr=0x10 data=0xDEADBEEF, dma_req=0 -> mem_we=1,
//    mem_addr=0x10, gnt=0; a following CPU read returns 0xDEADBEEF.
//  2 Idle DMA read: cpu_ce=0, dma_req=1 we=0 addr=0x20 (mem=0x12345678) ->
//    gnt=1 that cycle; next cycle rvalid=1, rdata=0x12345678.
//  3 Starvation, STARVE_MAX=4: cpu_ce=1 always, dma_req=1 write 0x30<=0xA5A5A5A5
//    -> gnt=0 for 4 cycles; cycle 5 gnt=1, stall=1, mem[0x30]=0xA5A5A5A5;
//    cycle 6 stall=0, cnt=0.
//  4 Request withdrawn: same as 3, but dma_req drops in the forced cycle ->
//    stall=0, gnt=0, force_q=0 next cycle.
//  5 Burst: cpu_ce=0, DMA writes 0x40,0x44,0x48 back to back -> 3 consecutive gnt,
//    memory holds all three words.
//  6 Async reset mid-op: rst=1 between edges while force_q=1 -> stall, gnt,
//    mem_ce and rvalid go 0 immediately; cnt=0 after release.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU data port and a DMA/debug master.
// CPU wins by default; a starvation counter forces one DMA slot that stalls the CPU.
module data_mem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_ce_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_data_i,
    output logic [DW-1:0] cpu_data_o,
    output logic          cpu_stall_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_data_i,
    output logic          dma_gnt_o,
    output logic          dma_rvalid_o,
    output logic [DW-1:0] dma_rdata_o,
    output logic          mem_ce_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    input  logic [DW-1:0] mem_data_i
);

    localparam logic [7:0] StarveMax  = 8'(STARVE_MAX);
    localparam logic [7:0] StarveLast = 8'(STARVE_MAX - 1);

    logic       r_force;
    logic [7:0] r_starve_cnt;
    logic       w_gnt;
    logic       w_force_nxt;
    logic [7:0] w_starve_nxt;

    always_comb begin
        w_gnt       = !rst && dma_req_i && (!cpu_ce_i || r_force);
        dma_gnt_o   = w_gnt;
        cpu_stall_o = !rst && r_force && dma_req_i;

        if (w_gnt) begin
            mem_ce_o   = 1'b1;
            mem_we_o   = dma_we_i;
            mem_addr_o = dma_addr_i;
            mem_data_o = dma_data_i;
        end else begin
            mem_ce_o   = cpu_ce_i && !rst;
            mem_we_o   = cpu_we_i && !rst;
            mem_addr_o = cpu_addr_i;
            mem_data_o = cpu_data_i;
        end

        cpu_data_o = (!w_gnt && cpu_ce_i && !rst) ? mem_data_i : '0;

        w_starve_nxt = r_starve_cnt;
        if (!dma_req_i || w_gnt) begin
            w_starve_nxt = 8'd0;
        end else if (r_starve_cnt < StarveMax) begin
            w_starve_nxt = r_starve_cnt + 8'd1;
        end

        // A forced slot lasts exactly one cycle, whether or not the DMA still wants it.
        w_force_nxt = 1'b0;
        if (!r_force) begin
            w_force_nxt = dma_req_i && !w_gnt && (r_starve_cnt == StarveLast);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_force      <= 1'b0;
            r_starve_cnt <= 8'd0;
            dma_rvalid_o <= 1'b0;
            dma_rdata_o  <= '0;
        end else begin
            r_force      <= w_force_nxt;
            r_starve_cnt <= w_starve_nxt;
            dma_rvalid_o <= w_gnt && !dma_we_i;
            if (w_gnt && !dma_we_i) begin
                dma_rdata_o <= mem_data_i;
            end
        end
    end

endmodule
